// File: rtl/ysyx_24070016_fetch_axil_pkg.sv
// Shared fetch definitions: FSM states, fetch error codes and the default boot PC.
// Also used by the LSU and the difftest hook.
package ysyx_24070016_fetch_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RESP = 3'd2,
        ST_OUT  = 3'd3,
        ST_WNPC = 3'd4
    } fetch_state_t;

    typedef enum logic [1:0] {
        FE_OK       = 2'b00,
        FE_BUS      = 2'b01,
        FE_MISALIGN = 2'b10
    } fetch_err_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24070016_fetch_axil.sv
// Multi-cycle instruction fetch: one AXI4-Lite read per instruction, handed to the IDU
// over valid/ready, then waits for the next PC before fetching again.
module ysyx_24070016_fetch_axil
    import ysyx_24070016_fetch_axil_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [1:0]      fetch_err,
    input  logic            npc_valid,
    input  logic [XLEN-1:0] npc,
    output logic            npc_ready
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    fetch_err_t      r_err;
    logic            w_npc_misaligned;

    assign w_npc_misaligned = (npc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_REQ;
            ST_REQ:  if (arready)    w_state_nxt = ST_RESP;
            ST_RESP: if (rvalid)     w_state_nxt = ST_OUT;
            ST_OUT:  if (inst_ready) w_state_nxt = ST_WNPC;
            ST_WNPC: if (npc_valid)  w_state_nxt = w_npc_misaligned ? ST_OUT : ST_REQ;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Misaligned next PCs skip the bus entirely and surface as a fetch error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_inst    <= '0;
            r_inst_pc <= RESET_PC;
            r_err     <= FE_OK;
        end else begin
            if (r_state == ST_RESP && rvalid) begin
                r_inst    <= rdata;
                r_inst_pc <= r_pc;
                r_err     <= (rresp != 2'b00) ? FE_BUS : FE_OK;
            end
            if (r_state == ST_WNPC && npc_valid) begin
                r_pc <= npc;
                if (w_npc_misaligned) begin
                    r_inst    <= '0;
                    r_inst_pc <= npc;
                    r_err     <= FE_MISALIGN;
                end
            end
        end
    end

    // Handshake outputs depend on the registered state only.
    assign arvalid    = (r_state == ST_REQ);
    assign rready     = (r_state == ST_RESP);
    assign inst_valid = (r_state == ST_OUT);
    assign npc_ready  = (r_state == ST_WNPC);
    assign araddr     = r_pc;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign fetch_err  = r_err;

endmodule

// File: tb/tb_ysyx_24070016_fetch_axil.sv
// Self-checking bench for the AXI-Lite fetch stage: directed scenarios then randomized
// transactions checked against a transaction-level model of the fetch loop.
module tb_ysyx_24070016_fetch_axil;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  fetch_err;
    logic        npc_valid;
    logic [31:0] npc;
    logic        npc_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    ysyx_24070016_fetch_axil #(
        .XLEN    (32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst      (inst),
        .inst_pc   (inst_pc),
        .fetch_err (fetch_err),
        .npc_valid (npc_valid),
        .npc       (npc),
        .npc_ready (npc_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // DUT is expected to be presenting an instruction in the current cycle.
    task automatic present(input int ir_wait, input logic [31:0] e_inst,
                           input logic [31:0] e_pc, input logic [1:0] e_err);
        chk("inst_valid", inst_valid, 1);
        chk("inst", inst, e_inst);
        chk("inst_pc", inst_pc, e_pc);
        chk("fetch_err", fetch_err, e_err);
        for (int i = 0; i < ir_wait; i++) begin
            inst_ready = 1'b0;
            rvalid     = 1'($urandom_range(0, 1));
            rdata      = $urandom;
            rresp      = 2'($urandom);
            npc_valid  = 1'($urandom_range(0, 1));
            npc        = $urandom;
            tick();
            chk("hold_valid", inst_valid, 1);
            chk("hold_inst", inst, e_inst);
            chk("hold_pc", inst_pc, e_pc);
            chk("hold_err", fetch_err, e_err);
            chk("no_ar_in_out", arvalid, 0);
        end
        rvalid     = 1'b0;
        npc_valid  = 1'b0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("valid_drop", inst_valid, 0);
        chk("npc_ready", npc_ready, 1);
        chk("no_ar_wnpc", arvalid, 0);
    endtask

    // DUT is expected to be requesting m_pc in the current cycle.
    task automatic fetch(input int ar_wait, input int r_wait, input int ir_wait,
                         input logic [31:0] data, input logic [1:0] resp);
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, m_pc);
        arready = 1'b0;
        for (int i = 0; i < ar_wait; i++) begin
            rvalid = 1'($urandom_range(0, 1));
            rdata  = $urandom;
            tick();
            chk("ar_hold_valid", arvalid, 1);
            chk("ar_hold_addr", araddr, m_pc);
        end
        rvalid  = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("ar_done", arvalid, 0);
        chk("rready", rready, 1);
        for (int i = 0; i < r_wait; i++) begin
            tick();
            chk("r_wait_rready", rready, 1);
            chk("r_wait_valid", inst_valid, 0);
        end
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        tick();
        rvalid = 1'b0;
        rdata  = $urandom;
        rresp  = 2'b00;
        chk("rready_drop", rready, 0);
        present(ir_wait, data, m_pc, (resp != 2'b00) ? 2'b01 : 2'b00);
    endtask

    task automatic give_npc(input int wait_cycles, input logic [31:0] v);
        for (int i = 0; i < wait_cycles; i++) begin
            chk("npc_ready_wait", npc_ready, 1);
            tick();
        end
        chk("npc_ready_offer", npc_ready, 1);
        npc_valid = 1'b1;
        npc       = v;
        tick();
        npc_valid = 1'b0;
        npc       = $urandom;
        m_pc      = v;
    endtask

    task automatic step(input logic [31:0] v, input int nw, input int aw, input int rw,
                        input int iw, input logic [31:0] data, input logic [1:0] resp);
        give_npc(nw, v);
        if (v[1:0] == 2'b00) begin
            fetch(aw, rw, iw, data, resp);
        end else begin
            chk("misalign_no_ar", arvalid, 0);
            present(iw, 32'h0, v, 2'b10);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [1:0]  resp;
        rst        = 1'b0;
        arready    = 1'b1;
        rdata      = 32'h0000_0413;
        rresp      = 2'b00;
        rvalid     = 1'b0;
        inst_ready = 1'b0;
        npc_valid  = 1'b0;
        npc        = 32'h0;
        m_pc       = RST_PC;
        repeat (3) tick();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_npc_ready", npc_ready, 0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_err", fetch_err, 0);
        chk("rst_inst_pc", inst_pc, RST_PC);

        // Boot fetch: IDLE cycle, then request at the reset PC.
        rst = 1'b1;
        chk("idle_no_ar", arvalid, 0);
        tick();
        fetch(0, 0, 0, 32'h0000_0413, 2'b00);

        // Jump with AR and IDU backpressure.
        step(32'h8000_0010, 2, 5, 1, 4, $urandom, 2'b00);
        // Misaligned next PC.
        step(32'h8000_0002, 0, 0, 0, 1, 32'h0, 2'b00);
        // Bus error response.
        step(32'h8000_0100, 1, 0, 0, 0, 32'hdead_beef, 2'b10);

        // Reset while waiting for R; stray rvalid during and right after reset.
        give_npc(0, 32'h8000_0200);
        chk("pre_rst_arvalid", arvalid, 1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("pre_rst_rready", rready, 1);
        rst = 1'b0;
        #1;
        chk("async_rst_rready", rready, 0);
        chk("async_rst_inst_pc", inst_pc, RST_PC);
        chk("async_rst_err", fetch_err, 0);
        rvalid = 1'b1;
        rdata  = 32'hbad0_bad0;
        rresp  = 2'b11;
        tick();
        chk("in_rst_rready", rready, 0);
        rst = 1'b1;
        tick();
        rvalid = 1'b0;
        rresp  = 2'b00;
        chk("post_rst_inst_valid", inst_valid, 0);
        chk("post_rst_inst", inst, 32'h0);
        m_pc = RST_PC;
        fetch(0, 1, 0, $urandom, 2'b00);

        for (int n = 0; n < 25; n++) begin
            v = $urandom;
            v[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(v, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom, resp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24070016_fetch_axil.md
# ysyx_24070016_fetch_axil

Multi-cycle instruction fetch stage that turns the single-cycle fetch into a bus master. It holds the architectural PC, issues one AXI4-Lite read per instruction, and presents the fetched word to the decoder through a valid/ready handshake. It then waits for the next-PC from the execute/writeback side before fetching again.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- XLEN, 32, address/data width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- araddr  output  XLEN  AR address; equals pc while arvalid.
- arvalid  output  1  AR valid.
- arready  input  1  AR ready.
- rdata  input  XLEN  R data.
- rresp  input  2  R response; nonzero = error.
- rvalid  input  1  R valid.
- rready  output  1  R ready.
- inst_valid  output  1  instruction available to IDU.
- inst_ready  input  1  IDU accepts instruction.
- inst  output  XLEN  fetched word.
- inst_pc  output  XLEN  PC of inst.
- fetch_err  output  2  00 ok, 01 bus error, 10 misaligned PC.
- npc_valid  input  1  next PC offered.
- npc  input  XLEN  next PC value.
- npc_ready  output  1  stage accepts npc.

## Operation
- FSM states: IDLE, REQ, RESP, OUT, WNPC. Reset state IDLE, pc=RESET_PC.
- IDLE -> REQ unconditionally after one cycle. arvalid is therefore never high during reset or in the first cycle after release.
- REQ: arvalid=1, araddr=pc. On arvalid&&arready -> RESP.
- RESP: rready=1. On rvalid, capture inst=rdata. Set fetch_err=01 if rresp!=0, else 00. Go to OUT.
- OUT: inst_valid=1. inst, inst_pc and fetch_err are held stable until inst_ready. On inst_ready -> WNPC.
- WNPC: npc_ready=1. On npc_valid: pc<=npc.
  - If npc[1:0]==0 -> REQ.
  - If npc[1:0]!=0: no bus access; inst<=32'h0, fetch_err<=10 -> OUT.
- npc_valid outside WNPC is ignored; no buffering.
- rvalid outside RESP is ignored; no outstanding-transaction counting beyond one.
- Output registers reset to zero: arvalid, rready, inst_valid, npc_ready, inst, fetch_err. inst_pc resets to RESET_PC.
- arvalid, rready, inst_valid and npc_ready are decodes of the registered state only, with no combinational path from inputs.

## Timing
- Minimum fetch-to-present latency with arready=1 and rvalid one cycle after the AR handshake:
  - cycle 0: REQ handshake.
  - cycle 1: R handshake.
  - cycle 2: inst_valid high.
- Minimum loop, from npc accepted to the next inst_valid, is 3 cycles. A misaligned npc reaches OUT in 1 cycle.
- AR: once arvalid rises it stays high with constant araddr until arready.
- OUT: if inst_ready is high in the first OUT cycle, the transfer completes that cycle.
- Reset mid-transaction: all state clears immediately and asynchronously. A late rvalid after reset is dropped, because the FSM is not in RESP.
- pc width is XLEN. There is no arithmetic in this stage; PC+4 is computed downstream.

## Structure
- Shared package: the fsm state enum, fetch_err codes (FE_OK, FE_BUS, FE_MISALIGN) and the default RESET_PC constant. These are reused by the LSU and the difftest hook.
- Single module. No sub-module, since the AXI-Lite read master is too small to split out.

## Test plan
- Reset release with arready=1 and rdata=32'h00000413 returning the cycle after AR:
  - arvalid must first assert in the 2nd cycle after rst high, with araddr=32'h8000_0000.
  - inst_valid must follow 2 cycles later with inst=32'h00000413 and fetch_err=00.
- Backpressure, with arready held low for 5 cycles and then inst_ready low for 4 cycles:
  - araddr and arvalid must stay constant throughout the AR stall.
  - inst must stay constant throughout the inst_ready stall.
  - inst_valid must fall the cycle after the handshake.
- npc=32'h8000_0010 accepted in WNPC -> the next AR carries araddr=32'h8000_0010, and inst_pc=32'h8000_0010 at OUT.
- Misaligned npc=32'h8000_0002 -> no arvalid pulse; the next cycle shows inst_valid=1, inst=0, fetch_err=10.
- rresp=2'b10 with rdata=32'hdeadbeef -> inst=32'hdeadbeef, fetch_err=01.
- rst asserted in RESP, then an rvalid pulse while in reset and in the IDLE cycle after release -> pulse ignored; a fresh fetch starts from 32'h8000_0000.
